rf_read_ctrl: RTL

Read-side controller for the 16×16 register array: it turns two independent read requests into one-hot read-enable wordlines on the array's tri-state bitlines, and captures the bitline values into registered responses. It sits between the decode stage and the register array, and is the read counterpart of the array's D/WriteReg write path. An optional bypass forwards a same-cycle write to a colliding read.

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_read_ctrl_if.sv | 46 ++++
 rtl/rf_read_port.sv | 78 +++++++
 rtl/rf_read_ctrl.sv | 43 ++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, types and wordline decode for the
// register-file read controller.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } port_state_e;

  // Register 0 is hardwired zero, so its wordline never fires.
  function automatic logic [NUM_REGS-1:0] rd_decode(reg_idx_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    v[0]   = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rf_read_ctrl_if.sv
// rf_read_ctrl_if: request/response handshakes, wordlines, bitlines
// and write snoop between decode, controller and register array.
interface rf_read_ctrl_if;
  import rf_pkg::*;

  logic                req1_valid;
  logic                req1_ready;
  reg_idx_t            req1_idx;
  logic                rsp1_valid;
  logic                rsp1_ready;
  reg_data_t           rsp1_data;
  logic                req2_valid;
  logic                req2_ready;
  reg_idx_t            req2_idx;
  logic                rsp2_valid;
  logic                rsp2_ready;
  reg_data_t           rsp2_data;
  logic [NUM_REGS-1:0] rd_en1;
  logic [NUM_REGS-1:0] rd_en2;
  reg_data_t           bitline1;
  reg_data_t           bitline2;
  logic                wr_en;
  reg_idx_t            wr_idx;
  reg_data_t           wr_data;

  modport slave (
    input  req1_valid, req1_idx, rsp1_ready,
    input  req2_valid, req2_idx, rsp2_ready,
    input  bitline1, bitline2,
    input  wr_en, wr_idx, wr_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output req2_ready, rsp2_valid, rsp2_data,
    output rd_en1, rd_en2
  );

  modport master (
    output req1_valid, req1_idx, rsp1_ready,
    output req2_valid, req2_idx, rsp2_ready,
    output bitline1, bitline2,
    output wr_en, wr_idx, wr_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  req2_ready, rsp2_valid, rsp2_data,
    input  rd_en1, rd_en2
  );

endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one read port FSM (IDLE/DRIVE/HOLD), wordline decode
// and capture register. Bypass of a colliding write under RF_BYPASS_EN.
module rf_read_port
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  reg_idx_t            i_req_idx,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output reg_data_t           o_rsp_data,
  output logic [NUM_REGS-1:0] o_rd_en,
  input  reg_data_t           i_bitline,
  input  logic                i_wr_en,
  input  reg_idx_t            i_wr_idx,
  input  reg_data_t           i_wr_data
);

  port_state_e r_state;
  reg_idx_t    r_idx;
  reg_data_t   r_data;
  reg_data_t   w_cap;

  always_comb begin
    if (r_idx == '0) w_cap = '0;
`ifdef RF_BYPASS_EN
    else if (i_wr_en && i_wr_idx == r_idx) w_cap = i_wr_data;
`endif
    else w_cap = i_bitline;
  end

`ifndef RF_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{i_wr_en, i_wr_idx, i_wr_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_idx   <= i_req_idx;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_data  <= w_cap;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_rsp_ready) begin
            if (i_req_valid) begin
              r_idx   <= i_req_idx;
              r_state <= ST_DRIVE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Wordline is a pure function of state so an async reset drops it at once.
  assign o_rd_en     = (r_state == ST_DRIVE) ? rd_decode(r_idx) : '0;
  assign o_req_ready = (r_state == ST_IDLE) ||
                       ((r_state == ST_HOLD) && i_rsp_ready);
  assign o_rsp_valid = (r_state == ST_HOLD);
  assign o_rsp_data  = r_data;

endmodule

// File: rtl/rf_read_ctrl.sv
// rf_read_ctrl: two independent read ports onto the 16x16 register array.
// Define RF_BYPASS_EN to forward a same-cycle write into a colliding read.
module rf_read_ctrl
  import rf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  rf_read_ctrl_if.slave bus
);

  rf_read_port u_port1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (bus.req1_valid),
    .o_req_ready (bus.req1_ready),
    .i_req_idx   (bus.req1_idx),
    .o_rsp_valid (bus.rsp1_valid),
    .i_rsp_ready (bus.rsp1_ready),
    .o_rsp_data  (bus.rsp1_data),
    .o_rd_en     (bus.rd_en1),
    .i_bitline   (bus.bitline1),
    .i_wr_en     (bus.wr_en),
    .i_wr_idx    (bus.wr_idx),
    .i_wr_data   (bus.wr_data)
  );

  rf_read_port u_port2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (bus.req2_valid),
    .o_req_ready (bus.req2_ready),
    .i_req_idx   (bus.req2_idx),
    .o_rsp_valid (bus.rsp2_valid),
    .i_rsp_ready (bus.rsp2_ready),
    .o_rsp_data  (bus.rsp2_data),
    .o_rd_en     (bus.rd_en2),
    .i_bitline   (bus.bitline2),
    .i_wr_en     (bus.wr_en),
    .i_wr_idx    (bus.wr_idx),
    .i_wr_data   (bus.wr_data)
  );

endmodule
